// File: rtl/full_adder_dataflow.sv
//------------------------------------------------------------------------------
// Module   : full_adder_dataflow
// Brief    : Dataflow full adder with registered copy, saturating carry counter
//            and sticky arithmetic self-check flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder_dataflow (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    output logic       sum,
    output logic       carry_out,
    output logic       sum_q,
    output logic       carry_out_q,
    output logic [7:0] carry_count,
    output logic       check_err
);

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic       w_sum;
    logic       w_carry;
    logic [1:0] w_ref;
    logic       w_known;
    logic       w_mismatch;

    logic       r_sum_q;
    logic       r_carry_out_q;
    logic [7:0] r_carry_count;
    logic       r_check_err;

    assign w_sum     = a ^ b ^ carry_in;
    assign w_carry   = (a & b) | (carry_in & (a ^ b));
    assign sum       = w_sum;
    assign carry_out = w_carry;

    // Reference result from plain addition, independent of the dataflow terms.
    assign w_ref      = {1'b0, a} + {1'b0, b} + {1'b0, carry_in};
    assign w_known    = ((a ^ b ^ carry_in) !== 1'bx);
    assign w_mismatch = w_known && ({w_carry, w_sum} != w_ref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q       <= 1'b0;
            r_carry_out_q <= 1'b0;
            r_carry_count <= 8'd0;
            r_check_err   <= 1'b0;
        end else begin
            r_sum_q       <= w_sum;
            r_carry_out_q <= w_carry;
            if (w_carry && (r_carry_count != c_CNT_MAX)) begin
                r_carry_count <= r_carry_count + 8'd1;
            end
            if (w_mismatch) begin
                r_check_err <= 1'b1;
            end
        end
    end

    assign sum_q       = r_sum_q;
    assign carry_out_q = r_carry_out_q;
    assign carry_count = r_carry_count;
    assign check_err   = r_check_err;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_dataflow.sv
//------------------------------------------------------------------------------
// Module   : tb_full_adder_dataflow
// Brief    : Self-checking bench for full_adder_dataflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_full_adder_dataflow;

    typedef struct packed {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       carry_in;
    logic       sum;
    logic       carry_out;
    logic       sum_q;
    logic       carry_out_q;
    logic [7:0] carry_count;
    logic       check_err;

    int total = 0;
    int bad   = 0;

    vec_t vecs [8];

    full_adder_dataflow dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .sum         (sum),
        .carry_out   (carry_out),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .carry_count (carry_count),
        .check_err   (check_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic va, input logic vb, input logic vc);
        a        = va;
        b        = vb;
        carry_in = vc;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    int unsigned m_cnt;
    int unsigned m_total;
    logic        m_s;
    logic        m_c;
    logic        ra;
    logic        rb;
    logic        rc;

    initial begin
        // Truth table entries: a, b, carry_in, sum, carry_out
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        #1;
        chk("reset sum_q", {7'd0, sum_q}, 8'd0);
        chk("reset carry_out_q", {7'd0, carry_out_q}, 8'd0);
        chk("reset carry_count", carry_count, 8'd0);
        chk("reset check_err", {7'd0, check_err}, 8'd0);

        set_in(1'b0, 1'b0, 1'b0);
        #0;
        chk("powerup sum", {7'd0, sum}, 8'd0);
        chk("powerup carry_out", {7'd0, carry_out}, 8'd0);

        // Exhaustive sweep, 1 time unit apart, while reset holds the registers
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].ci);
            #1;
            chk($sformatf("sweep%0d sum", i), {7'd0, sum}, {7'd0, vecs[i].s});
            chk($sformatf("sweep%0d carry", i), {7'd0, carry_out}, {7'd0, vecs[i].co});
            chk($sformatf("sweep%0d check_err", i), {7'd0, check_err}, 8'd0);
        end

        @(negedge clk);
        rst = 1'b0;

        // Registered path latency
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        chk("reg1 sum_q", {7'd0, sum_q}, 8'd0);
        chk("reg1 carry_out_q", {7'd0, carry_out_q}, 8'd1);
        tick();
        chk("reg2 sum_q", {7'd0, sum_q}, 8'd0);
        chk("reg2 carry_out_q", {7'd0, carry_out_q}, 8'd0);
        chk("reg count", carry_count, 8'd1);

        // Randomized run against an arithmetic model
        m_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            ra = 1'($urandom);
            rb = 1'($urandom);
            rc = 1'($urandom);
            set_in(ra, rb, rc);
            m_total = int'(ra) + int'(rb) + int'(rc);
            m_s = (m_total % 2) == 1;
            m_c = m_total >= 2;
            #1;
            chk("rand sum", {7'd0, sum}, {7'd0, m_s});
            chk("rand carry_out", {7'd0, carry_out}, {7'd0, m_c});
            tick();
            if (m_c && m_cnt < 255) m_cnt++;
            chk("rand sum_q", {7'd0, sum_q}, {7'd0, m_s});
            chk("rand carry_out_q", {7'd0, carry_out_q}, {7'd0, m_c});
            chk("rand carry_count", carry_count, 8'(m_cnt));
            chk("rand check_err", {7'd0, check_err}, 8'd0);
        end

        // Counter saturation
        pulse_rst();
        chk("sat cleared", carry_count, 8'd0);
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) chk("sat 254", carry_count, 8'd254);
            if (i == 255) chk("sat 255", carry_count, 8'd255);
        end
        chk("sat hold", carry_count, 8'd255);
        chk("sat sum_q", {7'd0, sum_q}, 8'd1);
        chk("sat carry_out_q", {7'd0, carry_out_q}, 8'd1);

        // Asynchronous reset between edges
        pulse_rst();
        for (int i = 0; i < 17; i++) tick();
        chk("async pre count", carry_count, 8'd17);
        #2;
        rst = 1'b1;
        #1;
        chk("async count", carry_count, 8'd0);
        chk("async sum_q", {7'd0, sum_q}, 8'd0);
        chk("async carry_out_q", {7'd0, carry_out_q}, 8'd0);
        chk("async sum live", {7'd0, sum}, 8'd1);
        chk("async carry live", {7'd0, carry_out}, 8'd1);
        set_in(1'b0, 1'b1, 1'b0);
        #1;
        chk("async sum follow", {7'd0, sum}, 8'd1);
        chk("async carry follow", {7'd0, carry_out}, 8'd0);
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b1);
        #1;
        chk("async no edge yet", carry_count, 8'd0);
        tick();
        chk("async first update", carry_count, 8'd1);

        // Checker: corrupt the sum for one edge
        set_in(1'b0, 1'b0, 1'b0);
        #1;
        chk("chk before", {7'd0, check_err}, 8'd0);
        force dut.w_sum = 1'b1;
        tick();
        release dut.w_sum;
        chk("chk set", {7'd0, check_err}, 8'd1);
        tick();
        tick();
        chk("chk sticky", {7'd0, check_err}, 8'd1);
        pulse_rst();
        chk("chk cleared", {7'd0, check_err}, 8'd0);
        tick();
        chk("chk stays clear", {7'd0, check_err}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/full_adder_dataflow.md
# full_adder_dataflow

Single-bit full adder in dataflow form. Combinational sum and carry outputs are computed directly from the three input bits. A registered copy of the result and a sticky self-check flag are added for use in clocked datapaths. It is the leaf bit-cell for ripple adders and serves as a reference cell for adder verification.

## Interface
- No parameters.
- clk  input  1  single clock; all registered state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  addend bit.
- b  input  1  addend bit.
- carry_in  input  1  incoming carry bit.
- sum  output  1  combinational sum, a ^ b ^ carry_in.
- carry_out  output  1  combinational carry, (a & b) | (carry_in & (a ^ b)).
- sum_q  output  1  sum registered one cycle.
- carry_out_q  output  1  carry_out registered one cycle.
- carry_count  output  8  number of clock edges at which carry_out was 1; saturates at 255.
- check_err  output  1  sticky flag: dataflow result disagreed with the independent arithmetic result.

## Operation
- sum and carry_out are pure continuous assignments of a, b and carry_in.
  - They contain no clock or reset dependency.
  - They settle within the same delta/time step as any input change.
- The independent check computes the 2-bit value {c, s} = a + b + carry_in by zero-extended addition.
- check_err is set on a rising edge when {carry_out, sum} != {c, s}.
  - Once set, it stays 1 until rst.
- X/Z handling:
  - Any input at X propagates X on sum/carry_out per Verilog operator semantics. This is not masked.
  - The checker ignores cycles where any input is X/Z, using a case-equality guard.
  - check_err must not go X.
- On each rising edge with rst low:
  - sum_q <= sum.
  - carry_out_q <= carry_out.
  - carry_count increments by 1 if carry_out == 1 and carry_count != 8'hFF; otherwise it holds.
- Truth table (a b carry_in -> sum carry_out):
  - 000->0 0
  - 001->1 0
  - 010->1 0
  - 011->0 1
  - 100->1 0
  - 101->0 1
  - 110->0 1
  - 111->1 1

## Timing
- Combinational path: zero latency from any input to sum/carry_out.
- Registered path: sum_q/carry_out_q reflect the inputs sampled at the previous rising edge, so latency is 1 cycle.
- rst asserted, at any time including mid-stream:
  - sum_q, carry_out_q, carry_count and check_err go to 0 immediately, without waiting for a clock edge.
  - The combinational outputs are unaffected.
- rst released: the first update occurs at the next rising edge.
- carry_count saturation: at 8'hFF it holds 8'hFF while carry_out stays 1. There is no wrap.
- Simultaneous rst and clock edge: reset wins.

## Test plan
- Exhaustive combinational sweep:
  - Apply the 8 input combinations in binary order 000..111, 1 time unit apart.
  - Require the sum/carry_out truth table above at every step.
  - Require check_err to stay 0.
- Power-up X:
  - Hold inputs at X before the first assignment; sum/carry_out read x.
  - Then apply a=0, b=0, carry_in=0 and require sum=0, carry_out=0 immediately.
- Registered path:
  - Drive a=1, b=1, carry_in=0 before an edge, then change to 000 after it.
  - Require sum_q=0, carry_out_q=1 after that edge.
  - Require sum_q=0, carry_out_q=0 after the next edge.
- Carry counter:
  - Hold a=1, b=1, carry_in=1 for 300 edges.
  - Require carry_count to reach 255 and hold there.
  - Require carry_out_q=1 and sum_q=1.
- Asynchronous reset mid-stream:
  - With carry_count=17, pulse rst between clock edges.
  - Require carry_count=0, sum_q=0 and carry_out_q=0 before the next edge.
  - Require sum/carry_out to keep following the inputs throughout.
- Checker:
  - Force sum to be inverted for one cycle.
  - Require check_err=1 from the next edge onward, cleared only by rst.
